// File: rtl/eth_speed_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : eth_speed_pkg
// Brief  : Link-speed encodings, normalisation and speed-sequencer states.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package eth_speed_pkg;

  localparam logic [1:0] SPEED_10M   = 2'b00;
  localparam logic [1:0] SPEED_100M  = 2'b01;
  localparam logic [1:0] SPEED_1000M = 2'b10;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_DRAIN  = 2'd1;
  localparam logic [ST_W-1:0] ST_RESET  = 2'd2;
  localparam logic [ST_W-1:0] ST_SETTLE = 2'd3;

  // 2'b11 is an alias of 1000M; folding it here keeps 2'b11 off the PHY port.
  function automatic logic [1:0] normalise(input logic [1:0] speed);
    return (speed == 2'b11) ? SPEED_1000M : speed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgmii_speed_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rgmii_speed_ctrl
// Brief  : Sequences RGMII speed changes: hold MAC, drain, reset PHY IF, settle.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module rgmii_speed_ctrl
  import eth_speed_pkg::*;
#(
  parameter logic [1:0] DEFAULT_SPEED     = 2'b10,
  parameter int         DRAIN_IDLE_CYCLES = 16,
  parameter int         DRAIN_TIMEOUT     = 4096,
  parameter int         RESET_CYCLES      = 8,
  parameter int         SETTLE_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cfg_speed_i,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic       mac_tx_en_i,
  output logic       mac_tx_hold_o,
  output logic       phy_if_rst_o,
  output logic [1:0] speed_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o
);

  localparam int MAX_RS    = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
  localparam int PHASE_MAX = (DRAIN_TIMEOUT > MAX_RS) ? DRAIN_TIMEOUT : MAX_RS;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int IDLE_W    = $clog2(DRAIN_IDLE_CYCLES + 1);

  logic [ST_W-1:0]    state;
  logic [ST_W-1:0]    next_state;
  logic [PHASE_W-1:0] phase_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [1:0]         target;
  logic               timed_out;
  logic               from_request;

  logic       accept;
  logic [1:0] req_speed;
  logic       same_speed;
  logic       drain_idle;
  logic       drain_timeout;
  logic       reset_end;
  logic       settle_end;
  logic       finish;

  assign accept        = cfg_valid_i && cfg_ready_o;
  assign req_speed     = normalise(cfg_speed_i);
  assign same_speed    = accept && (req_speed == speed_o);
  assign drain_idle    = (state == ST_DRAIN) && !mac_tx_en_i &&
                         (idle_cnt == IDLE_W'(DRAIN_IDLE_CYCLES - 1));
  assign drain_timeout = (state == ST_DRAIN) && (phase_cnt == PHASE_W'(DRAIN_TIMEOUT - 1));
  assign reset_end     = (state == ST_RESET) && (phase_cnt == PHASE_W'(RESET_CYCLES - 1));
  assign settle_end    = (state == ST_SETTLE) && (phase_cnt == PHASE_W'(SETTLE_CYCLES - 1));
  assign finish        = settle_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept && !same_speed)         next_state = ST_DRAIN;
      ST_DRAIN:  if (drain_idle || drain_timeout)   next_state = ST_RESET;
      ST_RESET:  if (reset_end)                     next_state = ST_SETTLE;
      ST_SETTLE: if (settle_end)                    next_state = ST_IDLE;
      default:                                      next_state = ST_RESET;
    endcase
  end

  always_comb begin
    cfg_ready_o   = (state == ST_IDLE);
    mac_tx_hold_o = (state != ST_IDLE);
    busy_o        = (state != ST_IDLE);
    phy_if_rst_o  = (state == ST_RESET);
  end

  // from_request separates host-initiated switches from the power-on pass,
  // which must complete silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt    <= '0;
      idle_cnt     <= '0;
      target       <= normalise(DEFAULT_SPEED);
      speed_o      <= normalise(DEFAULT_SPEED);
      timed_out    <= 1'b0;
      from_request <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      if ((next_state != state) || (state == ST_IDLE)) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + PHASE_W'(1);
      end

      if ((state == ST_DRAIN) && (next_state == ST_DRAIN) && !mac_tx_en_i) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
        idle_cnt <= '0;
      end

      if ((state == ST_IDLE) && (next_state == ST_DRAIN)) begin
        target       <= req_speed;
        from_request <= 1'b1;
      end

      // Quiet line wins a tie with the timeout, so only a pure timeout flags.
      if ((state == ST_DRAIN) && (next_state == ST_RESET)) begin
        speed_o   <= target;
        timed_out <= drain_timeout && !drain_idle;
      end

      if (finish) begin
        from_request <= 1'b0;
        timed_out    <= 1'b0;
      end

      done_o    <= same_speed || (finish && from_request);
      timeout_o <= finish && from_request && timed_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgmii_speed_ctrl.sv
`default_nettype none
// Bench for rgmii_speed_ctrl: vector table, power-on / async-reset sequences,
// and a randomized run against a schedule computed from the timing rules.
module tb_rgmii_speed_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg_speed_i = 2'b00;
  logic       cfg_valid_i = 1'b0;
  logic       mac_tx_en_i = 1'b0;
  logic       cfg_ready_o;
  logic       mac_tx_hold_o;
  logic       phy_if_rst_o;
  logic [1:0] speed_o;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;

  rgmii_speed_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_speed_i  (cfg_speed_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .mac_tx_en_i  (mac_tx_en_i),
    .mac_tx_hold_o(mac_tx_hold_o),
    .phy_if_rst_o (phy_if_rst_o),
    .speed_o      (speed_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // {ready, hold, phy_rst, speed[1:0], busy, done, timeout}
  localparam logic [7:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0};

  typedef struct {
    logic [1:0] req;
    int         n_high;
    logic       switch_exp;
    int         rst_at;
    int         done_at;
    logic       to_exp;
    logic [1:0] speed_exp;
  } vec_t;

  vec_t vecs[8];

  localparam int MAXC   = 8000;
  localparam int RAND_L = 2500;
  bit         tx_a  [MAXC];
  bit         val_a [MAXC];
  logic [1:0] spd_a [MAXC];
  bit         e_busy[MAXC];
  bit         e_rst [MAXC];
  bit         e_done[MAXC];
  bit         e_to  [MAXC];
  logic [1:0] e_spd [MAXC];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] obs();
    return {cfg_ready_o, mac_tx_hold_o, phy_if_rst_o, speed_o, busy_o, done_o, timeout_o};
  endfunction

  // Caller leaves rst high and returns control away from a clock edge.
  task automatic power_on(input string tag);
    int rst_low_at;
    int ready_at;
    int hold_low_at;
    int bad_speed;
    int dones;
    rst_low_at = -1; ready_at = -1; hold_low_at = -1; bad_speed = 0; dones = 0;
    chk({tag, " reset outputs"}, obs(), RESET_VEC);
    for (int k = 0; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == 0) rst = 1'b0;
      cfg_valid_i = 1'b0;
      mac_tx_en_i = 1'b0;
      @(negedge clk);
      if (rst_low_at < 0 && !phy_if_rst_o) rst_low_at = k;
      if (ready_at < 0 && cfg_ready_o) ready_at = k;
      if (hold_low_at < 0 && !mac_tx_hold_o) hold_low_at = k;
      if (speed_o != 2'b10) bad_speed++;
      if (done_o) dones++;
    end
    chk({tag, " phy reset length"}, rst_low_at, 8);
    chk({tag, " ready rise"}, ready_at, 72);
    chk({tag, " hold drop"}, hold_low_at, 72);
    chk({tag, " speed stays 1000M"}, bad_speed, 0);
    chk({tag, " no done pulse"}, dones, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rst_at, done_at, to_at_done, dones, hold_low, busy_cnt, limit;
    rst_at = 0; done_at = 0; to_at_done = 0; dones = 0; hold_low = 0; busy_cnt = 0;
    limit = v.done_at + 3;
    chk($sformatf("vec%0d ready before request", idx), cfg_ready_o, 1);
    for (int k = 0; k <= limit; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        cfg_valid_i = 1'b1;
        cfg_speed_i = v.req;
        mac_tx_en_i = 1'b0;
      end else begin
        cfg_valid_i = 1'b0;
        cfg_speed_i = 2'($urandom);
        mac_tx_en_i = (k <= v.n_high);
      end
      @(negedge clk);
      if (rst_at == 0 && phy_if_rst_o) rst_at = k;
      if (done_o) begin
        dones++;
        if (done_at == 0) begin
          done_at    = k;
          to_at_done = timeout_o;
        end
      end
      if (busy_o) busy_cnt++;
      if (k >= 1 && k < v.done_at && !mac_tx_hold_o) hold_low++;
    end
    chk($sformatf("vec%0d reset entry cycle", idx), rst_at, v.rst_at);
    chk($sformatf("vec%0d done cycle", idx), done_at, v.done_at);
    chk($sformatf("vec%0d done pulses", idx), dones, 1);
    chk($sformatf("vec%0d timeout flag", idx), to_at_done, int'(v.to_exp));
    chk($sformatf("vec%0d final speed", idx), speed_o, v.speed_exp);
    if (v.switch_exp) chk($sformatf("vec%0d hold gaps", idx), hold_low, 0);
    else              chk($sformatf("vec%0d busy cycles", idx), busy_cnt, 0);
  endtask

  task automatic mid_settle_reset();
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      cfg_valid_i = (k == 0);
      cfg_speed_i = 2'b00;
      mac_tx_en_i = 1'b0;
      @(negedge clk);
    end
    chk("switch to 10M in SETTLE", {phy_if_rst_o, busy_o, speed_o}, 4'b0100);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async reset outputs", obs(), RESET_VEC);
    @(negedge clk);
    power_on("re-power-on");
  endtask

  function automatic bit quiet_window(input int t, input int d);
    if (t - 15 < d) return 1'b0;
    for (int j = t - 15; j <= t; j++) if (tx_a[j]) return 1'b0;
    return 1'b1;
  endfunction

  // Whole-run schedule from the rules: a switch accepted at a drains from a+1,
  // leaves at the first 16-quiet-cycle window or at 4096 cycles, then 8 reset
  // plus 64 settle cycles, with done on the following cycle.
  task automatic build_random(output int t_end);
    int t, len, r, a, d, e, idle_from, prev_a;
    bit lvl, timed;
    logic [1:0] cur, s, ns;
    t = 0;
    while (t < MAXC) begin
      len = $urandom_range(1, 40);
      lvl = 1'($urandom_range(0, 1));
      for (int j = 0; j < len && t < MAXC; j++) begin
        tx_a[t] = lvl;
        t++;
      end
    end
    for (int i = 0; i < MAXC; i++) begin
      val_a[i] = 1'b0; spd_a[i] = 2'($urandom);
      e_busy[i] = 1'b0; e_rst[i] = 1'b0; e_done[i] = 1'b0; e_to[i] = 1'b0;
      e_spd[i] = 2'b10;
    end
    cur = 2'b10; idle_from = 0; prev_a = -1; r = 0;
    while (1) begin
      r = r + $urandom_range(1, 120);
      if (r < prev_a + 1) r = prev_a + 1;
      if (r > RAND_L) break;
      s  = 2'($urandom);
      ns = (s == 2'b11) ? 2'b10 : s;
      a  = (r > idle_from) ? r : idle_from;
      for (int i = r; i <= a; i++) begin
        val_a[i] = 1'b1;
        spd_a[i] = s;
      end
      if (ns == cur) begin
        e_done[a + 1] = 1'b1;
        idle_from = a + 1;
      end else begin
        d = a + 1;
        e = d + 4095;
        timed = 1'b1;
        for (int c = d + 15; c <= d + 4095; c++) begin
          if (quiet_window(c, d)) begin
            e = c;
            timed = 1'b0;
            break;
          end
        end
        for (int i = d; i <= e + 72; i++) e_busy[i] = 1'b1;
        for (int i = e + 1; i <= e + 8; i++) e_rst[i] = 1'b1;
        for (int i = e + 1; i < MAXC; i++) e_spd[i] = ns;
        e_done[e + 73] = 1'b1;
        e_to[e + 73]   = timed;
        idle_from = e + 73;
        cur = ns;
      end
      prev_a = a;
    end
    t_end = idle_from + 5;
  endtask

  task automatic run_random();
    int t_end;
    logic [7:0] expv;
    build_random(t_end);
    for (int t = 0; t < t_end; t++) begin
      @(posedge clk); #1;
      cfg_valid_i = val_a[t];
      cfg_speed_i = spd_a[t];
      mac_tx_en_i = tx_a[t];
      @(negedge clk);
      expv = {!e_busy[t], e_busy[t], e_rst[t], e_spd[t], e_busy[t], e_done[t], e_to[t]};
      chk($sformatf("random cycle %0d outputs", t), obs(), expv);
    end
  endtask

  initial begin
    vecs[0] = '{2'b11, 0,    1'b0, 0,    1,    1'b0, 2'b10};
    vecs[1] = '{2'b01, 0,    1'b1, 17,   89,   1'b0, 2'b01};
    vecs[2] = '{2'b00, 200,  1'b1, 217,  289,  1'b0, 2'b00};
    vecs[3] = '{2'b00, 0,    1'b0, 0,    1,    1'b0, 2'b00};
    vecs[4] = '{2'b10, 4200, 1'b1, 4097, 4169, 1'b1, 2'b10};
    vecs[5] = '{2'b01, 4080, 1'b1, 4097, 4169, 1'b0, 2'b01};
    vecs[6] = '{2'b11, 4081, 1'b1, 4097, 4169, 1'b1, 2'b10};
    vecs[7] = '{2'b01, 5,    1'b1, 22,   94,   1'b0, 2'b01};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    power_on("power-on");
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    mid_settle_reset();
    run_random();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
